// File: rtl/fetch_unit.sv
// Instruction fetch unit: it keeps the PC, fetches one halfword over a
// request/valid handshake, and holds the IR until downstream advances.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    input  logic        MemValid,
    input  logic [15:0] MemData,
    input  logic        Advance,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] BranchTarget,
    input  logic [15:0] JumpTarget,
    input  logic [15:0] JrData,
    output logic [15:0] PC,
    output logic [15:0] PCPlus2,
    output logic [15:0] IR,
    output logic        InstValid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] w_pcPlus2;
    logic [15:0] w_nextPc;

    assign w_pcPlus2 = r_pc + 16'd2;

    always_comb begin
        w_nextPc = w_pcPlus2;
        case (PCSrc)
            2'b00:   w_nextPc = w_pcPlus2;
            2'b01:   w_nextPc = BranchTarget;
            2'b10:   w_nextPc = JumpTarget;
            2'b11:   w_nextPc = JrData;
            default: w_nextPc = w_pcPlus2;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: w_nextState = S_WAIT;
            S_WAIT:  if (MemValid) w_nextState = S_HOLD;
            S_HOLD:  if (Advance) w_nextState = S_FETCH;
            default: w_nextState = S_FETCH;
        endcase
    end

    // Reset wins over everything, so a MemValid arriving with it is dropped.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC_ALIGNED;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_WAIT && MemValid) begin
                r_ir <= MemData;
            end
            if (r_state == S_HOLD && Advance) begin
                r_pc <= w_nextPc & 16'hFFFE;
            end
        end
    end

    assign MemReq    = (r_state == S_FETCH) || (r_state == S_WAIT);
    assign MemAddr   = r_pc;
    assign InstValid = (r_state == S_HOLD);
    assign PC        = r_pc;
    assign PCPlus2   = w_pcPlus2;
    assign IR        = r_ir;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model checked on
// every cycle, plus directed vectors with literal expectations.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemValid;
    logic [15:0] MemData;
    logic        Advance;
    logic [1:0]  PCSrc;
    logic [15:0] BranchTarget;
    logic [15:0] JumpTarget;
    logic [15:0] JrData;
    logic [15:0] PC;
    logic [15:0] PCPlus2;
    logic [15:0] IR;
    logic        InstValid;

    int nChecks = 0;
    int nPass   = 0;

    // Model: ready = IR holds an instruction; age = cycles since fetch began.
    bit mInit  = 0;
    bit mReady = 0;
    int mAge   = 0;
    int mPc    = 0;
    int mIr    = 0;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .CLK(CLK), .Reset(Reset), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemValid(MemValid), .MemData(MemData), .Advance(Advance),
        .PCSrc(PCSrc), .BranchTarget(BranchTarget), .JumpTarget(JumpTarget),
        .JrData(JrData), .PC(PC), .PCPlus2(PCPlus2), .IR(IR),
        .InstValid(InstValid)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge CLK) begin
        int target;
        if (Reset) begin
            mInit  = 1;
            mPc    = 0;
            mIr    = 0;
            mReady = 0;
            mAge   = 0;
        end else if (mInit) begin
            if (mReady) begin
                if (Advance) begin
                    case (PCSrc)
                        2'b00:   target = (mPc + 2) % 65536;
                        2'b01:   target = int'(BranchTarget);
                        2'b10:   target = int'(JumpTarget);
                        default: target = int'(JrData);
                    endcase
                    mPc    = target - (target % 2);
                    mReady = 0;
                    mAge   = 0;
                end
            end else if (mAge >= 1 && MemValid) begin
                mIr    = int'(MemData);
                mReady = 1;
            end else begin
                mAge++;
            end
        end
    end

    always @(negedge CLK) begin
        if (mInit) begin
            checkOutput("modelPC", PC, 16'(mPc));
            checkOutput("modelPCPlus2", PCPlus2, 16'((mPc + 2) % 65536));
            checkOutput("modelIR", IR, 16'(mIr));
            checkOutput("modelMemAddr", MemAddr, 16'(mPc));
            checkOutput("modelMemReq", {15'b0, MemReq}, {15'b0, !mReady});
            checkOutput("modelInstValid", {15'b0, InstValid}, {15'b0, mReady});
        end
    end

    task automatic applyStimulus(input logic rst, input logic mv, input logic [15:0] md,
                                 input logic adv, input logic [1:0] src);
        Reset    = rst;
        MemValid = mv;
        MemData  = md;
        Advance  = adv;
        PCSrc    = src;
        @(posedge CLK);
        #1;
    endtask

    task automatic doFetch(input logic [15:0] data);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b1, data, 1'b0, 2'b00);
    endtask

    initial begin
        BranchTarget = 16'h0000;
        JumpTarget   = 16'h0000;
        JrData       = 16'h0000;

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 2'b00);
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1, 2'b11);
        checkOutput("resetMemReq", {15'b0, MemReq}, 16'd1);
        checkOutput("resetMemAddr", MemAddr, 16'h0000);
        checkOutput("resetInstValid", {15'b0, InstValid}, 16'd0);
        checkOutput("resetIR", IR, 16'h0000);

        // FETCH cycle ignores MemValid; first WAIT cycle returns 1234
        applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, 2'b00);
        checkOutput("firstWaitInstValid", {15'b0, InstValid}, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0, 2'b00);
        checkOutput("minLatInstValid", {15'b0, InstValid}, 16'd1);
        checkOutput("minLatIR", IR, 16'h1234);
        checkOutput("minLatPC", PC, 16'h0000);
        checkOutput("minLatPCPlus2", PCPlus2, 16'h0002);

        applyStimulus(1'b0, 1'b1, 16'h5555, 1'b0, 2'b00);
        checkOutput("holdIR", IR, 16'h1234);
        checkOutput("holdInstValid", {15'b0, InstValid}, 16'd1);

        BranchTarget = 16'h0010;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 2'b01);
        checkOutput("branchMemAddr", MemAddr, 16'h0010);
        checkOutput("branchMemReq", {15'b0, MemReq}, 16'd1);
        checkOutput("branchInstValid", {15'b0, InstValid}, 16'd0);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0, 2'b00);
        checkOutput("slowIR", IR, 16'h1111);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 2'b00);
        checkOutput("seqMemAddr", MemAddr, 16'h0012);

        doFetch(16'h2222);
        JrData = 16'h0009;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 2'b11);
        checkOutput("jrMemAddr", MemAddr, 16'h0008);

        doFetch(16'h3333);
        JumpTarget = 16'hFFFF;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 2'b10);
        checkOutput("jumpMemAddr", MemAddr, 16'hFFFE);
        checkOutput("wrapPCPlus2", PCPlus2, 16'h0000);

        doFetch(16'h4444);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 2'b00);
        checkOutput("wrapMemAddr", MemAddr, 16'h0000);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'b00);
            checkOutput("stallMemReq", {15'b0, MemReq}, 16'd1);
            checkOutput("stallInstValid", {15'b0, InstValid}, 16'd0);
        end
        applyStimulus(1'b0, 1'b1, 16'hABCD, 1'b0, 2'b00);
        checkOutput("stallIR", IR, 16'hABCD);
        checkOutput("stallDoneInstValid", {15'b0, InstValid}, 16'd1);

        // Advance outside HOLD must not move the PC; then reset during WAIT
        BranchTarget = 16'h0100;
        JumpTarget   = 16'h0200;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b1, 16'h9999, 1'b1, 2'b10);
        checkOutput("advInFetchPC", PC, 16'h0100);
        applyStimulus(1'b1, 1'b1, 16'h7777, 1'b0, 2'b00);
        checkOutput("rstWaitIR", IR, 16'h0000);
        checkOutput("rstWaitPC", PC, 16'h0000);
        checkOutput("rstWaitMemReq", {15'b0, MemReq}, 16'd1);
        checkOutput("rstWaitInstValid", {15'b0, InstValid}, 16'd0);

        doFetch(16'h5A5A);
        checkOutput("refetchIR", IR, 16'h5A5A);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 2'b10);
        checkOutput("rstHoldInstValid", {15'b0, InstValid}, 16'd0);
        checkOutput("rstHoldPC", PC, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 2'b00);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
